pipelined_mul: RTL

PIPELINED_MUL -- requirements
Module: pipelined_mul

---
 rtl/pipelined_mul.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pipelined_mul.sv
// pipelined_mul
//   Pipelined sign/magnitude multiplier with per-stage valid bits and
//   backpressure. Operands are turned into magnitudes when they are accepted.
//   Each accumulate stage adds WIDTH/STAGES shifted partial products. The last
//   stage negates the sum when the product sign is negative. Bubbles collapse
//   into empty stages behind a stall.
//
//   Pipeline slots:
//     slot 0        : capture register (magnitudes of a/b, product sign)
//     slot 1..STAGES: accumulate stages; slot STAGES drives product
//   An entry taken at edge N is in slot STAGES, with out_valid high, after
//   edge N+STAGES.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset; clears every valid bit
//   in_valid   operand pair on a/b/is_signed is valid
//   in_ready   block accepts the operand pair this cycle
//   a, b       WIDTH-bit multiplicand / multiplier
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   out_valid  product is valid
//   out_ready  downstream accepts the product this cycle
//   product    2*WIDTH-bit full product
//   busy       at least one slot holds a valid entry
//
// Handshake: a transfer happens on a rising edge where valid && ready on the
// same side. A producer may change its data freely while not transferring.
// in_ready depends combinationally on out_ready through the advance chain.
// out_valid and product come straight from registers and stay stable while
// out_ready is low.
module pipelined_mul #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int PW    = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE_W = 1;
  localparam logic [PW-1:0]    ONE_P = 1;

  logic [STAGES:0]    valid_q;
  logic [STAGES:0]    adv;
  logic [WIDTH-1:0]   mag_a_q [0:STAGES-1];
  logic [WIDTH-1:0]   mag_b_q [0:STAGES-1];
  logic [STAGES-1:0]  neg_q;
  // acc_q[0] is never loaded; it stays zero and seeds the first accumulate stage.
  logic [PW-1:0]      acc_q   [0:STAGES];
  logic [PW-1:0]      acc_d   [1:STAGES];

  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic               neg_in;

  // Magnitudes at capture time. The most-negative value maps to 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits, so no case overflows.
  always_comb begin
    mag_a_in = (is_signed && a[WIDTH-1]) ? (~a + ONE_W) : a;
    mag_b_in = (is_signed && b[WIDTH-1]) ? (~b + ONE_W) : b;
    neg_in   = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  // A slot advances when it is empty or when the slot after it advances.
  // The output slot advances when it is empty or on an output transfer.
  always_comb begin
    adv = '0;
    adv[STAGES] = !valid_q[STAGES] || out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = !valid_q[k] || adv[k+1];
    end
  end

  // Stage k adds the partial products for multiplier bits
  // [(k-1)*CHUNK +: CHUNK]. The final stage also applies the sign.
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      acc_d[k] = acc_q[k-1];
      for (int j = 0; j < CHUNK; j++) begin
        if (mag_b_q[k-1][(k-1)*CHUNK + j]) begin
          acc_d[k] = acc_d[k] + (PW'(mag_a_q[k-1]) << ((k-1)*CHUNK + j));
        end
      end
      if (k == STAGES && neg_q[k-1]) begin
        acc_d[k] = ~acc_d[k] + ONE_P;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      neg_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        mag_a_q[k] <= '0;
        mag_b_q[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      // Capture slot
      if (adv[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          mag_a_q[0] <= mag_a_in;
          mag_b_q[0] <= mag_b_in;
          neg_q[0]   <= neg_in;
        end
      end
      // Valid bits and accumulators. Data registers load only with a real
      // entry, so a stalled or empty slot keeps its contents.
      for (int k = 1; k <= STAGES; k++) begin
        if (adv[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            acc_q[k] <= acc_d[k];
          end
        end
      end
      // Operand magnitudes and sign travel with the entry.
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k] && valid_q[k-1]) begin
          mag_a_q[k] <= mag_a_q[k-1];
          mag_b_q[k] <= mag_b_q[k-1];
          neg_q[k]   <= neg_q[k-1];
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[STAGES];
  assign product   = acc_q[STAGES];
  assign busy      = |valid_q;

endmodule
